pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It merges per-stage stall requests into the per-register stall vector that drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It schedules the EX-stage multi-cycle multiply/divide hold. It issues a one-cycle pipeline flush with redirect PC on exceptions, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: stall merge, mul/div hold, exception flush.
// Also keeps a saturating stall-cycle counter.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  input  logic        md_start,
  input  logic [5:0]  md_cycles,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        md_done,
  output logic        md_abort,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] V_MEM = 6'b011111;
  localparam logic [5:0] V_EX  = 6'b001111;
  localparam logic [5:0] V_ID  = 6'b000111;

  state_t     state;
  logic [5:0] md_cnt;
  logic [5:0] md_len;
  logic [5:0] req_vec;
  logic [5:0] md_hold;
  logic       cnt_max;

  assign md_len  = (md_cycles == 6'd0) ? 6'd1 : md_cycles;
  assign cnt_max = &stall_cnt;

  always_comb begin
    req_vec = '0;
    unique case (1'b1)
      stallreq_mem:
        req_vec = V_MEM;
      !stallreq_mem && stallreq_ex:
        req_vec = V_EX;
      !stallreq_mem && !stallreq_ex && stallreq_id:
        req_vec = V_ID;
      default:
        req_vec = '0;
    endcase
  end

  // EX is held from the md_start cycle until the final count.
  always_comb begin
    md_hold = '0;
    unique case (state)
      RUN:     md_hold = md_start ? V_EX : '0;
      BUSY:    md_hold = (md_cnt > 6'd1) ? V_EX : '0;
      default: md_hold = '0;
    endcase
  end

  always_comb begin
    stall = '0;
    if (!rst && (state == RUN || state == BUSY))
      stall = req_vec | md_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= '0;
      flush     <= 1'b0;
      new_pc    <= '0;
      md_done   <= 1'b0;
      md_abort  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      flush    <= 1'b0;
      md_done  <= 1'b0;
      md_abort <= 1'b0;
      if (stall[0] && !cnt_max)
        stall_cnt <= stall_cnt + 32'd1;
      unique case (state)
        RUN: begin
          if (excp_req) begin
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= excp_pc;
          end else if (md_start) begin
            state   <= BUSY;
            md_cnt  <= md_len;
            md_done <= (md_len == 6'd1);
          end
        end
        BUSY: begin
          if (excp_req) begin
            state    <= FLUSH;
            md_cnt   <= '0;
            flush    <= 1'b1;
            new_pc   <= excp_pc;
            md_abort <= 1'b1;
          end else begin
            md_cnt  <= md_cnt - 6'd1;
            md_done <= (md_cnt == 6'd2);
            if (md_cnt <= 6'd1)
              state <= RUN;
          end
        end
        FLUSH:
          state <= RUN;
        default:
          state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expectations queued
// by the driver, compared on the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic        md_start;
  logic [5:0]  md_cycles;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        md_done;
  logic        md_abort;
  logic [31:0] stall_cnt;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_req     (excp_req),
    .excp_pc      (excp_pc),
    .md_start     (md_start),
    .md_cycles    (md_cycles),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .md_done      (md_done),
    .md_abort     (md_abort),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        abort;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec;
  int          n_err;
  logic [31:0] e_cnt;
  logic [31:0] e_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
      chk({e.tag, ".flush"}, 32'(flush), 32'(e.flush));
      chk({e.tag, ".new_pc"}, new_pc, e.pc);
      chk({e.tag, ".done"}, 32'(md_done), 32'(e.done));
      chk({e.tag, ".abort"}, 32'(md_abort), 32'(e.abort));
      chk({e.tag, ".cnt"}, stall_cnt, e.cnt);
    end
  end

  task automatic push(
    input string      tag,
    input logic [5:0] e_stall,
    input logic       e_flush,
    input logic       e_done,
    input logic       e_abort
  );
    exp_t e;
    e.tag   = tag;
    e.stall = e_stall;
    e.flush = e_flush;
    e.pc    = e_pc;
    e.done  = e_done;
    e.abort = e_abort;
    e.cnt   = e_cnt;
    sb.push_back(e);
    if (e_stall[0] && e_cnt != 32'hFFFFFFFF)
      e_cnt = e_cnt + 32'd1;
  endtask

  task automatic rcyc(input string tag);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    stallreq_id  = 1'b1;
    stallreq_ex  = 1'b1;
    stallreq_mem = 1'b1;
    excp_req     = 1'b1;
    excp_pc      = 32'hDEADBEEF;
    md_start     = 1'b1;
    md_cycles    = 6'd5;
    push(tag, 6'b0, 1'b0, 1'b0, 1'b0);
    e_cnt = '0;
    e_pc  = '0;
  endtask

  task automatic drive(
    input string       tag,
    input logic        id,
    input logic        ex,
    input logic        mem,
    input logic        excp,
    input logic [31:0] pc,
    input logic        st,
    input logic [5:0]  n,
    input logic [5:0]  e_stall,
    input logic        e_flush,
    input logic        e_done,
    input logic        e_abort
  );
    @(posedge clk);
    #1;
    rst          = 1'b0;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excp_req     = excp;
    excp_pc      = pc;
    md_start     = st;
    md_cycles    = n;
    push(tag, e_stall, e_flush, e_done, e_abort);
  endtask

  task automatic idle(input string tag, input logic [5:0] e_stall,
                      input logic e_done);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, e_stall, 0, e_done, 0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    e_cnt        = '0;
    e_pc         = '0;
    rst          = 1'b1;
    stallreq_id  = 1'b1;
    stallreq_ex  = 1'b1;
    stallreq_mem = 1'b1;
    excp_req     = 1'b1;
    excp_pc      = 32'hDEADBEEF;
    md_start     = 1'b1;
    md_cycles    = 6'd5;

    rcyc("rst0");
    rcyc("rst1");

    drive("pri_mi", 1, 0, 1, 0, 0, 0, 0, 6'b011111, 0, 0, 0);
    drive("pri_ei", 1, 1, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
    drive("pri_i", 1, 0, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0);
    idle("pri_idle", 6'b0, 0);

    drive("md4_k", 0, 0, 0, 0, 0, 1, 4, 6'b001111, 0, 0, 0);
    drive("md4_b1", 1, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
    drive("md4_b2", 0, 0, 1, 0, 0, 0, 0, 6'b011111, 0, 0, 0);
    idle("md4_b3", 6'b001111, 0);
    drive("md4_done", 0, 0, 0, 0, 0, 1, 4, 6'b0, 0, 1, 0);
    idle("md4_run", 6'b0, 0);

    drive("md0_k", 0, 0, 0, 0, 0, 1, 0, 6'b001111, 0, 0, 0);
    idle("md0_done", 6'b0, 1);
    idle("md0_run", 6'b0, 0);

    drive("ex_k", 0, 1, 0, 1, 32'hBFC00380, 0, 0,
          6'b001111, 0, 0, 0);
    e_pc = 32'hBFC00380;
    drive("ex_fl", 0, 1, 0, 1, 32'h12345678, 1, 3,
          6'b0, 1, 0, 0);
    drive("ex_after", 0, 1, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
    idle("ex_run", 6'b0, 0);

    drive("ab_k", 0, 0, 0, 0, 0, 1, 10, 6'b001111, 0, 0, 0);
    idle("ab_b1", 6'b001111, 0);
    idle("ab_b2", 6'b001111, 0);
    drive("ab_b3", 0, 0, 0, 1, 32'h80000180, 0, 0,
          6'b001111, 0, 0, 0);
    e_pc = 32'h80000180;
    drive("ab_fl", 0, 0, 0, 0, 0, 0, 0, 6'b0, 1, 0, 1);
    for (int i = 0; i < 10; i++)
      idle($sformatf("ab_run%0d", i), 6'b0, 0);
    drive("ab_md1", 0, 0, 0, 0, 0, 1, 1, 6'b001111, 0, 0, 0);
    idle("ab_md1d", 6'b0, 1);

    @(negedge clk);
    #1;
    force dut.stall_cnt = 32'hFFFFFFFE;
    #1;
    release dut.stall_cnt;
    e_cnt = 32'hFFFFFFFE;
    for (int i = 0; i < 3; i++)
      drive($sformatf("sat%0d", i), 1, 0, 0, 0, 0, 0, 0,
            6'b000111, 0, 0, 0);
    idle("sat_h0", 6'b0, 0);
    idle("sat_h1", 6'b0, 0);

    drive("rr_k", 0, 0, 0, 0, 0, 1, 8, 6'b001111, 0, 0, 0);
    idle("rr_b1", 6'b001111, 0);
    rcyc("rr_rst0");
    rcyc("rr_rst1");
    idle("rr_run", 6'b0, 0);
    drive("rr_md", 0, 0, 0, 0, 0, 1, 2, 6'b001111, 0, 0, 0);
    idle("rr_b", 6'b001111, 0);
    idle("rr_d", 6'b0, 1);
    idle("rr_end", 6'b0, 0);

    @(negedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
